// File: rtl/tagger_acq_ctrl.sv
// Acquisition sequencer between host commands, event_tagger and the record FIFO.
// Optional lost-record marker insertion is built when TAGGER_LOST_MARKER_EN is defined.
module tagger_acq_ctrl #(
  parameter int DUR_W  = 48,
  parameter int REC_W  = 47,
  parameter int CNT_W  = 32,
  parameter int LOST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              timed_en,
  input  logic [DUR_W-1:0]  duration,
  input  logic              tag_ready,
  input  logic [REC_W-1:0]  tag_data,
  input  logic              fifo_full,
  output logic              reset_counter,
  output logic              operate,
  output logic              fifo_wr,
  output logic [REC_W-1:0]  fifo_din,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  rec_count,
  output logic [LOST_W-1:0] lost_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_STOP} state_t;

  state_t             state, state_nxt;
  logic               timed_q;
  logic [DUR_W-1:0]   dur_q, dur_cnt;
  logic               start, accept, drop;
  logic               reset_counter_nxt, operate_nxt, running_nxt, done_nxt;
  logic               marker_wr;
  logic [REC_W-1:0]   marker_rec;

  assign start  = (state == S_IDLE) && cmd_start;
  assign accept = (state == S_RUN) && tag_ready && !fifo_full;
  assign drop   = (state == S_RUN) && tag_ready && fifo_full;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (cmd_start) state_nxt = S_ARM;
      S_ARM:  state_nxt = S_RUN;
      S_RUN:  if (cmd_stop || (timed_q && dur_cnt == dur_q)) state_nxt = S_STOP;
      S_STOP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state register.
    reset_counter_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ARM);
    operate_nxt       = (state_nxt == S_RUN);
    running_nxt       = (state_nxt == S_RUN);
    done_nxt          = (state_nxt == S_STOP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      reset_counter <= 1'b1;
      operate       <= 1'b0;
      running       <= 1'b0;
      done          <= 1'b0;
      timed_q       <= 1'b0;
      dur_q         <= '0;
      dur_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      reset_counter <= reset_counter_nxt;
      operate       <= operate_nxt;
      running       <= running_nxt;
      done          <= done_nxt;
      if (start) begin
        timed_q <= timed_en;
        // A zero duration behaves as one so RUN always lasts at least a cycle.
        dur_q   <= (duration == '0) ? DUR_W'(1) : duration;
      end
      if (state == S_ARM)      dur_cnt <= DUR_W'(1);
      else if (state == S_RUN) dur_cnt <= dur_cnt + DUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr    <= 1'b0;
      fifo_din   <= '0;
      rec_count  <= '0;
      lost_count <= '0;
    end else begin
      fifo_wr <= accept || marker_wr;
      if (accept)         fifo_din <= tag_data;
      else if (marker_wr) fifo_din <= marker_rec;
      if (start)                        rec_count <= '0;
      else if (accept || marker_wr)     rec_count <= rec_count + CNT_W'(1);
      if (start)                        lost_count <= '0;
      else if (drop && lost_count != '1) lost_count <= lost_count + LOST_W'(1);
    end
  end

`ifdef TAGGER_LOST_MARKER_EN
  logic [15:0] episode_cnt;

  // A pending marker goes out on the first free FIFO slot not taken by a real record.
  assign marker_wr = (episode_cnt != '0) && ((state == S_RUN) || (state == S_STOP)) &&
                     !fifo_full && !accept;

  always_comb begin
    marker_rec        = '0;
    marker_rec[44]    = 1'b1;
    marker_rec[15:0]  = episode_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      episode_cnt <= '0;
    end else if (start || state == S_STOP || marker_wr) begin
      episode_cnt <= '0;
    end else if (drop && episode_cnt != '1) begin
      episode_cnt <= episode_cnt + 16'd1;
    end
  end
`else
  assign marker_wr  = 1'b0;
  assign marker_rec = '0;
`endif

endmodule
